// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: each channel counts to its divisor and
// produces a square wave (mode 0) or a one-cycle pulse (mode 1), plus a terminal tick.
module prog_clk_divider #(
    parameter int          NUM_CH      = 2,
    parameter int          WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 9000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_clr,
    input  logic [NUM_CH-1:0] enable,
    input  logic              load_en,
    input  logic [2:0]        load_ch,
    input  logic [WIDTH-1:0]  load_div,
    input  logic              load_mode,
    output logic [NUM_CH-1:0] sclk,
    output logic [NUM_CH-1:0] tick
);

    logic [WIDTH-1:0]  count_q [NUM_CH];
    logic [WIDTH-1:0]  count_d [NUM_CH];
    logic [WIDTH-1:0]  div_q   [NUM_CH];
    logic [WIDTH-1:0]  div_d   [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] sclk_q, sclk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              load_hit;

    // Load strobe: a single-cycle load_en with an in-range load_ch is always accepted,
    // with no backpressure; out-of-range channel indices are silently dropped.
    assign load_hit = load_en && ({29'd0, load_ch} < $unsigned(NUM_CH));

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i] = count_q[i];
            div_d[i]   = div_q[i];
            mode_d[i]  = mode_q[i];
            sclk_d[i]  = sclk_q[i];
            tick_d[i]  = 1'b0;

            // Priority: clear, then load, then counting.
            if (sync_clr) begin
                count_d[i] = '0;
                sclk_d[i]  = 1'b0;
            end else if (load_hit && (load_ch == 3'(i))) begin
                div_d[i]   = load_div;
                mode_d[i]  = load_mode;
                count_d[i] = '0;
                sclk_d[i]  = 1'b0;
            end else if (enable[i]) begin
                if (count_q[i] == div_q[i]) begin
                    count_d[i] = '0;
                    tick_d[i]  = 1'b1;
                    sclk_d[i]  = mode_q[i] ? 1'b1 : ~sclk_q[i];
                end else begin
                    count_d[i] = count_q[i] + 1'b1;
                    if (mode_q[i]) begin
                        sclk_d[i] = 1'b0;
                    end
                end
            end else if (mode_q[i]) begin
                sclk_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= '0;
                div_q[i]   <= WIDTH'(DEFAULT_DIV);
            end
            mode_q <= '0;
            sclk_q <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= count_d[i];
                div_q[i]   <= div_d[i];
            end
            mode_q <= mode_d;
            sclk_q <= sclk_d;
            tick_q <= tick_d;
        end
    end

    assign sclk = sclk_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: two channels, default divisor 3, with
// hand-derived waveforms for load, enable gating, clear and asynchronous reset.
module tb_prog_clk_divider;

    localparam int          NUM_CH      = 2;
    localparam int          WIDTH       = 8;
    localparam int unsigned DEFAULT_DIV = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sync_clr;
    logic [NUM_CH-1:0] enable;
    logic              load_en;
    logic [2:0]        load_ch;
    logic [WIDTH-1:0]  load_div;
    logic              load_mode;
    logic [NUM_CH-1:0] sclk;
    logic [NUM_CH-1:0] tick;

    int vectors     = 0;
    int miscompares = 0;

    prog_clk_divider #(
        .NUM_CH     (NUM_CH),
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sync_clr (sync_clr),
        .enable   (enable),
        .load_en  (load_en),
        .load_ch  (load_ch),
        .load_div (load_div),
        .load_mode(load_mode),
        .sclk     (sclk),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // One active edge, then settle away from it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] exp_sclk, input logic [1:0] exp_tick);
        chk({tag, " sclk"}, sclk, exp_sclk);
        chk({tag, " tick"}, tick, exp_tick);
    endtask

    // Mode-0 reference from count 0 / sclk 0, with period p = div+1 edges.
    function automatic logic sclk_ref(input int k, input int p);
        return ((k / p) % 2) == 1;
    endfunction

    function automatic logic tick_ref(input int k, input int p);
        return (k % p) == 0;
    endfunction

    initial begin
        sync_clr  = 1'b0;
        enable    = '0;
        load_en   = 1'b0;
        load_ch   = '0;
        load_div  = '0;
        load_mode = 1'b0;

        #1;
        reset = 1'b0;
        #2;
        check_out("reset", 2'b00, 2'b00);

        #9;
        reset  = 1'b1;
        enable = 2'b11;

        // Default divisor 3: tick every 4 edges, sclk toggles every 4 edges.
        for (int k = 1; k <= 16; k++) begin
            step();
            check_out($sformatf("dflt k%0d", k), {2{sclk_ref(k, 4)}}, {2{tick_ref(k, 4)}});
        end

        load_en   = 1'b1;
        load_ch   = 3'd1;
        load_div  = 8'd0;
        load_mode = 1'b1;
        step();
        check_out("load ch1", {1'b0, sclk_ref(17, 4)}, {1'b0, tick_ref(17, 4)});
        load_en = 1'b0;

        // ch1 now div 0 / pulse mode: high every cycle; ch0 keeps its rhythm.
        for (int k = 18; k <= 30; k++) begin
            step();
            check_out($sformatf("div0 k%0d", k), {1'b1, sclk_ref(k, 4)}, {1'b1, tick_ref(k, 4)});
        end

        // ch0 sits at count 2 with sclk high; gating must hold both.
        enable = 2'b10;
        for (int h = 1; h <= 5; h++) begin
            step();
            check_out($sformatf("hold h%0d", h), 2'b11, 2'b10);
        end
        enable = 2'b11;

        for (int k = 31; k <= 39; k++) begin
            step();
            check_out($sformatf("resume k%0d", k), {1'b1, sclk_ref(k, 4)}, {1'b1, tick_ref(k, 4)});
        end

        // ch0 reaches terminal count on this edge, but the load wins.
        load_en   = 1'b1;
        load_ch   = 3'd0;
        load_div  = 8'd1;
        load_mode = 1'b0;
        step();
        check_out("load at tc", 2'b10, 2'b10);
        load_en = 1'b0;

        for (int j = 1; j <= 6; j++) begin
            step();
            check_out($sformatf("div1 j%0d", j), {1'b1, sclk_ref(j, 2)}, {1'b1, tick_ref(j, 2)});
        end

        sync_clr  = 1'b1;
        load_en   = 1'b1;
        load_ch   = 3'd0;
        load_div  = 8'd5;
        load_mode = 1'b1;
        step();
        check_out("clr+load", 2'b00, 2'b00);
        sync_clr = 1'b0;
        load_en  = 1'b0;

        // ch0 must still be div 1 / mode 0 and ch1 still div 0 / mode 1.
        for (int j = 1; j <= 4; j++) begin
            step();
            check_out($sformatf("after clr j%0d", j), {1'b1, sclk_ref(j, 2)}, {1'b1, tick_ref(j, 2)});
        end

        load_en   = 1'b1;
        load_ch   = 3'd5;
        load_div  = 8'd0;
        load_mode = 1'b1;
        for (int j = 5; j <= 8; j++) begin
            step();
            check_out($sformatf("ch5 j%0d", j), {1'b1, sclk_ref(j, 2)}, {1'b1, tick_ref(j, 2)});
        end
        load_en = 1'b0;

        // Outputs are non-zero here; reset must clear them before the next edge.
        #3;
        reset = 1'b0;
        #1;
        check_out("async rst", 2'b00, 2'b00);
        step();
        check_out("rst held", 2'b00, 2'b00);
        #2;
        reset = 1'b1;

        for (int k = 1; k <= 8; k++) begin
            step();
            check_out($sformatf("post rst k%0d", k), {2{sclk_ref(k, 4)}}, {2{tick_ref(k, 4)}});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
